// File: rtl/l2_mem_pkg.sv
// Shared types and defaults for the banked L2 memory controller.
package l2_mem_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      DRAIN = 2'd1,
      RUN   = 2'd2
   } l2_state_e;

   localparam int unsigned L2_DATA_WIDTH = 32;
   localparam int unsigned L2_BANK_WORDS = 8192;

   // Number of byte lanes in a data word.
   function automatic int unsigned be_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/l2_bank_sram.sv
// Behavioural single-port SRAM bank with byte enables and a 1-cycle read.
// The port mux gives the zeroing sweep priority over the channel access.
module l2_bank_sram
   import l2_mem_pkg::*;
#(
   parameter int unsigned WORDS      = L2_BANK_WORDS,
   parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
   localparam int unsigned AW        = $clog2(WORDS),
   localparam int unsigned BW        = be_width(DATA_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  sweep_i,
   input  logic [AW-1:0]         sweep_addr_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [BW-1:0]         be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [WORDS];

   logic                  en;
   logic                  we;
   logic [AW-1:0]         addr;
   logic [BW-1:0]         be;
   logic [DATA_WIDTH-1:0] wdata;

   always_comb begin
      en    = req_i;
      we    = we_i;
      addr  = addr_i;
      be    = be_i;
      wdata = wdata_i;
      if (sweep_i) begin
         en    = 1'b1;
         we    = 1'b1;
         addr  = sweep_addr_i;
         be    = '1;
         wdata = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < int'(BW); b++) begin
               if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata_o <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/l2_ram_banked_ctrl.sv
// Multi-bank L2 memory: zeroing sweep, read-valid responses, range checking.
// Define L2_RDATA_REG_EN to add an output register stage (read latency 2).
module l2_ram_banked_ctrl
   import l2_mem_pkg::*;
#(
   parameter int unsigned NB_BANKS      = 4,
   parameter int unsigned BANK_WORDS    = L2_BANK_WORDS,
   parameter int unsigned DATA_WIDTH    = L2_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH    = $clog2(BANK_WORDS),
   parameter bit          INIT_ON_RESET = 1'b1,
   localparam int unsigned BE_WIDTH     = be_width(DATA_WIDTH)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 clear_i,
   output logic                                 init_done_o,
   input  logic [NB_BANKS-1:0]                  req_i,
   input  logic [NB_BANKS-1:0][ADDR_WIDTH-1:0]  add_i,
   input  logic [NB_BANKS-1:0]                  wen_i,
   input  logic [NB_BANKS-1:0][BE_WIDTH-1:0]    be_i,
   input  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]  wdata_i,
   output logic [NB_BANKS-1:0]                  gnt_o,
   output logic [NB_BANKS-1:0]                  r_valid_o,
   output logic [NB_BANKS-1:0][DATA_WIDTH-1:0]  r_rdata_o,
   output logic [NB_BANKS-1:0]                  r_err_o
);

`ifdef L2_RDATA_REG_EN
   localparam int unsigned DRAIN_CYCLES = 2;
`else
   localparam int unsigned DRAIN_CYCLES = 1;
`endif
   localparam l2_state_e RESET_STATE = INIT_ON_RESET ? INIT : RUN;

   l2_state_e                             state_q;
   l2_state_e                             state_d;
   logic [ADDR_WIDTH-1:0]                 cnt_q;
   logic                                  drain_q;
   logic                                  sweep_c;
   logic                                  sweep_last_c;
   logic                                  drain_last_c;
   logic [NB_BANKS-1:0]                   in_range_c;
   logic [NB_BANKS-1:0]                   bank_en_c;
   logic [NB_BANKS-1:0]                   rsp_valid_q;
   logic [NB_BANKS-1:0]                   rsp_err_q;
   logic [NB_BANKS-1:0]                   rsp_rd_q;
   logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   bank_rdata;
   logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   rsp_rdata_c;

   assign sweep_last_c = (cnt_q == ADDR_WIDTH'(BANK_WORDS - 1));
   assign drain_last_c = (32'(drain_q) == DRAIN_CYCLES - 32'd1);

   // State register plus sweep and drain counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == INIT && !sweep_last_c) ? cnt_q + ADDR_WIDTH'(1) : '0;
         drain_q <= (state_q == DRAIN && !drain_last_c);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (sweep_last_c) state_d = RUN;
         DRAIN:   if (drain_last_c) state_d = INIT;
         RUN:     if (clear_i)      state_d = DRAIN;
         default: state_d = RESET_STATE;
      endcase
   end

   always_comb begin
      sweep_c     = 1'b0;
      init_done_o = 1'b0;
      gnt_o       = '0;
      case (state_q)
         INIT: sweep_c = 1'b1;
         RUN: begin
            init_done_o = 1'b1;
            gnt_o       = req_i;
         end
         default: ;
      endcase
      bank_en_c = gnt_o & in_range_c;
   end

   // Range check handles bank depths that are not a power of two
   always_comb begin
      for (int i = 0; i < int'(NB_BANKS); i++) begin
         in_range_c[i] = (32'(add_i[i]) < BANK_WORDS);
      end
   end

   for (genvar g = 0; g < int'(NB_BANKS); g++) begin : g_bank
      l2_bank_sram #(
         .WORDS      (BANK_WORDS),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .clk_i        (clk_i),
         .sweep_i      (sweep_c),
         .sweep_addr_i (cnt_q),
         .req_i        (bank_en_c[g]),
         .we_i         (~wen_i[g]),
         .addr_i       (add_i[g]),
         .be_i         (be_i[g]),
         .wdata_i      (wdata_i[g]),
         .rdata_o      (bank_rdata[g])
      );
   end

   // First response stage: one pulse per grant, data only for in-range reads
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q <= '0;
         rsp_err_q   <= '0;
         rsp_rd_q    <= '0;
      end else begin
         rsp_valid_q <= gnt_o;
         rsp_err_q   <= gnt_o & ~in_range_c;
         rsp_rd_q    <= gnt_o & wen_i & in_range_c;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NB_BANKS); i++) begin
         rsp_rdata_c[i] = rsp_rd_q[i] ? bank_rdata[i] : '0;
      end
   end

`ifdef L2_RDATA_REG_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid_o <= '0;
         r_err_o   <= '0;
         r_rdata_o <= '0;
      end else begin
         r_valid_o <= rsp_valid_q;
         r_err_o   <= rsp_err_q;
         r_rdata_o <= rsp_rdata_c;
      end
   end
`else
   always_comb begin
      r_valid_o = rsp_valid_q;
      r_err_o   = rsp_err_q;
      r_rdata_o = rsp_rdata_c;
   end
`endif

endmodule

// File: doc/l2_ram_banked_ctrl.md
# l2_ram_banked_ctrl

Parametrised multi-bank L2 memory block: NB_BANKS independent single-port SRAM banks, each with its own TCDM-style request/grant/response channel. Adds behaviour the fixed-configuration L2 wrapper lacks:

- hardware zero-initialisation sweep after reset or on request;
- an explicit read-valid response;
- out-of-range address detection for non-power-of-two bank depths.

Sits between the SoC L2 interconnect and the physical banks.

## Interface
Parameters:
- NB_BANKS, 4, number of banks/channels (1..16)
- BANK_WORDS, 8192, words per bank (any value >= 2, need not be a power of two)
- DATA_WIDTH, 32, word width in bits (multiple of 8)
- ADDR_WIDTH, $clog2(BANK_WORDS), word address width (derived; do not override)
- INIT_ON_RESET, 1, 1: run the zeroing sweep after reset; 0: go straight to RUN

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- clear_i  in  1  pulse; re-enter zeroing sweep
- init_done_o  out  1  high when banks are usable (state RUN)
- req_i  in  [NB_BANKS]  per-bank request
- add_i  in  [NB_BANKS][ADDR_WIDTH]  word address
- wen_i  in  [NB_BANKS]  0 = write, 1 = read
- be_i  in  [NB_BANKS][DATA_WIDTH/8]  byte enables, active-high
- wdata_i  in  [NB_BANKS][DATA_WIDTH]  write data
- gnt_o  out  [NB_BANKS]  grant
- r_valid_o  out  [NB_BANKS]  response valid
- r_rdata_o  out  [NB_BANKS][DATA_WIDTH]  read data
- r_err_o  out  [NB_BANKS]  response error (out-of-range address)

## Operation
State machine, states INIT, DRAIN, RUN:
- **INIT**
  - Sweep counter cnt runs 0..BANK_WORDS-1, one word per cycle.
  - Writes all-zero with all byte enables to address cnt in every bank simultaneously.
  - gnt_o = 0.
  - At cnt = BANK_WORDS-1 → RUN.
- **RUN**
  - gnt_o[i] = req_i[i] (combinational, no back-pressure).
  - A granted access is performed on that cycle's edge.
  - clear_i = 1 → DRAIN.
- **DRAIN**
  - gnt_o = 0.
  - Waits one cycle (two with L2_RDATA_REG_EN) so in-flight responses complete, then → INIT with cnt = 0.
- clear_i is ignored in INIT and DRAIN.

Access rules (RUN):
- A read returns the addressed word.
- A write updates only the bytes with be_i set.
- Every granted access, read or write, produces exactly one r_valid_o pulse.
- Write responses drive r_rdata_o = 0.
- add_i >= BANK_WORDS: access suppressed (no bank enable, no write). Response still issued with r_err_o = 1 and r_rdata_o = 0. Only reachable when BANK_WORDS is not a power of two.
- Banks are fully independent; simultaneous requests to different banks all complete in the same cycle.

## Timing
- Reset values, applied at the rst_i edge:
  - gnt_o, r_valid_o, r_err_o = 0; r_rdata_o = 0; cnt = 0.
  - State = INIT if INIT_ON_RESET, else RUN.
  - init_done_o = 0 if INIT_ON_RESET, else 1.
- Reset mid-sweep restarts the sweep at cnt = 0. Reset mid-access drops the pending response.
- Read latency:
  - Without L2_RDATA_REG_EN: r_valid_o/r_rdata_o/r_err_o are asserted the cycle after grant.
  - With L2_RDATA_REG_EN: two cycles after grant.
- Back-to-back accesses: one per bank per cycle, responses in order.
- Sweep duration: exactly BANK_WORDS cycles in INIT.
- init_done_o rises in the cycle after the last sweep write. It falls the cycle after clear_i is sampled in RUN.
- Bank contents are not reset; only the sweep clears them. With INIT_ON_RESET = 0, contents are undefined until written.

## Configuration
- L2_RDATA_REG_EN defined:
  - Extra register stage on r_valid_o, r_rdata_o, r_err_o per bank; read latency 2.
  - DRAIN lasts 2 cycles.
- L2_RDATA_REG_EN undefined:
  - Outputs come straight from the bank output; latency 1.
  - DRAIN lasts 1 cycle.
- Grant behaviour is identical in both builds.

## Structure
- Package l2_mem_pkg holds:
  - state enum l2_state_e {INIT, DRAIN, RUN};
  - default constants L2_DATA_WIDTH = 32, L2_BANK_WORDS = 8192;
  - a helper function computing byte-enable width.
- Sub-module l2_bank_sram:
  - Behavioural single-port RAM with byte enables and 1-cycle read.
  - Parameters: WORDS, DATA_WIDTH.
  - Instantiated NB_BANKS times.
  - Its port mux selects sweep or channel access.
- FSM, sweep counter, range check and response pipeline live in the top module.

## Test plan
- **Reset sweep:** INIT_ON_RESET = 1, BANK_WORDS = 8, rst_i high 2 cycles → gnt_o stays 0, init_done_o rises exactly 8 cycles after reset release, and reads of all addresses return 0x0000_0000 with r_err_o = 0.
- **Byte-enable write:** write 0xDEADBEEF to bank 2, address 5, be = 4'b0101, then read → r_rdata_o = 0x00AD00EF one cycle after the read grant (two with L2_RDATA_REG_EN).
- **Parallel banks:** all 4 banks write on the same cycle, then all read on the same cycle → four simultaneous r_valid_o pulses with correct per-bank data. Write responses have r_rdata_o = 0.
- **Out of range:** BANK_WORDS = 6, write to add = 7, then read add = 7 and add = 5 → first two responses have r_err_o = 1 and r_rdata_o = 0; the add = 5 read has r_err_o = 0; no bank word is modified.
- **Clear during traffic:** clear_i pulses in the same cycle as a granted read → that read's response still arrives, gnt_o drops, init_done_o falls, and after DRAIN + BANK_WORDS cycles previously written data reads as 0.
- **Reset mid-sweep:** rst_i asserted at cnt = 3 → sweep restarts at 0, and init_done_o rises BANK_WORDS cycles after release.
